ppu_pixel_writer: RTL

- Write side of the PPU-to-VGA strip buffer. Watches the PPU pixel stream (xIdx, yIdx, pal_index) and turns each newly produced visible pixel into one write into the 8192-entry palette-index buffer.
- Buffer address is {y[4:0], x[7:0]}, so the buffer holds a 32-line strip. The VGA side reads it back.
- Also reports line, strip and frame boundaries, and detects a stream that falls out of sync.

---
 rtl/ppu_pixel_writer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ppu_pixel_writer.sv
// ppu_pixel_writer: write side of the PPU-to-VGA strip buffer.
// Turns each new visible PPU pixel into one buffer write one cycle later,
// and flags line/strip/frame boundaries, resyncs and skipped dots.
`timescale 1ns/1ps
module ppu_pixel_writer #(
  parameter int H_VISIBLE   = 256,
  parameter int V_VISIBLE   = 240,
  parameter int ADDR_Y_BITS = 5,
  parameter int ADDR_X_BITS = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [8:0]                         xIdx,
  input  logic [8:0]                         yIdx,
  input  logic [4:0]                         pal_index,
  output logic                               wr_en,
  output logic [ADDR_Y_BITS+ADDR_X_BITS-1:0] wr_addr,
  output logic [4:0]                         wr_data,
  output logic                               line_done,
  output logic                               strip_done,
  output logic                               frame_done,
  output logic                               frame_abort,
  output logic                               skip_err,
  output logic [7:0]                         frame_count,
  output logic                               synced
);

  localparam int                     AW         = ADDR_Y_BITS + ADDR_X_BITS;
  localparam logic [8:0]             X_LAST     = 9'(H_VISIBLE);
  localparam logic [8:0]             Y_LAST     = 9'(V_VISIBLE - 1);
  localparam logic [ADDR_Y_BITS-1:0] STRIP_LAST = '1;

  typedef enum logic [1:0] {ST_SYNC, ST_ACTIVE, ST_VBLANK} state_t;

  state_t                 state_q, state_d;
  logic [8:0]             x_prev_q;
  logic                   wr_en_q, wr_en_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [4:0]             wr_data_q, wr_data_d;
  logic                   line_q, line_d;
  logic                   strip_q, strip_d;
  logic                   frame_q, frame_d;
  logic                   abort_q, abort_d;
  logic                   skip_q, skip_d;
  logic [7:0]             fcount_q, fcount_d;

  logic                   pix_event;
  logic                   at_origin;
  logic                   visible;
  logic [ADDR_X_BITS-1:0] pix_x;

  // A dot counter change is the only thing that marks a new pixel; PPU x
  // runs one ahead of the pixel it describes, hence the -1.
  assign pix_event = enable && (xIdx != x_prev_q);
  assign at_origin = (xIdx == 9'd0) && (yIdx == 9'd0);
  assign visible   = pix_event && (xIdx >= 9'd1) && (xIdx <= X_LAST) && (yIdx <= Y_LAST);
  assign pix_x     = ADDR_X_BITS'(xIdx - 9'd1);

  // Next-state and registered-output decode for the sync FSM.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    line_d    = 1'b0;
    strip_d   = 1'b0;
    frame_d   = 1'b0;
    abort_d   = 1'b0;
    skip_d    = 1'b0;
    fcount_d  = fcount_q;
    case (state_q)
      ST_SYNC, ST_VBLANK: begin
        if (pix_event && at_origin) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (pix_event && at_origin) begin
          // Frame restarted early: abandon it and begin the new one at once.
          abort_d = 1'b1;
        end else if (visible) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {yIdx[ADDR_Y_BITS-1:0], pix_x};
          wr_data_d = pal_index;
          skip_d    = (xIdx != x_prev_q + 9'd1);
          if (xIdx == X_LAST) begin
            line_d  = 1'b1;
            strip_d = (yIdx[ADDR_Y_BITS-1:0] == STRIP_LAST) || (yIdx == Y_LAST);
            if (yIdx == Y_LAST) begin
              frame_d  = 1'b1;
              fcount_d = fcount_q + 8'd1;
              state_d  = ST_VBLANK;
            end
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // State and output registers; x_prev tracks xIdx even while disabled so
  // re-enabling never produces a stale event.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_SYNC;
      x_prev_q  <= 9'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 5'd0;
      line_q    <= 1'b0;
      strip_q   <= 1'b0;
      frame_q   <= 1'b0;
      abort_q   <= 1'b0;
      skip_q    <= 1'b0;
      fcount_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      x_prev_q  <= xIdx;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      line_q    <= line_d;
      strip_q   <= strip_d;
      frame_q   <= frame_d;
      abort_q   <= abort_d;
      skip_q    <= skip_d;
      fcount_q  <= fcount_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign line_done   = line_q;
  assign strip_done  = strip_q;
  assign frame_done  = frame_q;
  assign frame_abort = abort_q;
  assign skip_err    = skip_q;
  assign frame_count = fcount_q;
  assign synced      = (state_q != ST_SYNC);

endmodule
